// File: rtl/pc_fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl_pkg
// Shared definitions for the instruction fetch stage: word width, the
// zero word, the default PC increment, the fetch FSM state encoding and a
// word-alignment helper used by the optional alignment check.
// Optional feature macro used by the importing files: PC_ALIGN_CHECK_EN.
// ---------------------------------------------------------------------------
package pc_fetch_ctrl_pkg;

    localparam int WORD_WIDTH = 32;
    localparam logic [WORD_WIDTH-1:0] ZERO_WORD = '0;
    localparam int INST_BYTES_DEFAULT = 4;

    // FETCH_FAULT is only reachable when the alignment check is compiled in.
    typedef enum logic [2:0] {
        FETCH_IDLE  = 3'd0,
        FETCH_REQ   = 3'd1,
        FETCH_WAIT  = 3'd2,
        FETCH_HOLD  = 3'd3,
        FETCH_FAULT = 3'd4
    } fetch_state_e;

    function automatic logic is_word_aligned(input logic [WORD_WIDTH-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// ---------------------------------------------------------------------------
// pc_target_calc
// Purely combinational redirect decode: decides whether a redirect is taken
// and computes its target address. Kept separate so a future branch
// predictor can reuse the same target arithmetic.
// Ports:
//   redir_jump, redir_can_branch, redir_branch_take : redirect qualifiers
//   redir_targ_else_offset : 1 = absolute target, 0 = PC-relative offset
//   redir_src_reg          : base from redir_rs_val (1) or redir_imm (0)
//   redir_rs_val, redir_imm, redir_pc : operands (W bits)
//   take                   : redirect is taken this cycle
//   target                 : redirect target address (modulo 2^W)
// ---------------------------------------------------------------------------
module pc_target_calc
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int W          = WORD_WIDTH,
    parameter int INST_BYTES = INST_BYTES_DEFAULT
) (
    input  logic         redir_jump,
    input  logic         redir_can_branch,
    input  logic         redir_branch_take,
    input  logic         redir_targ_else_offset,
    input  logic         redir_src_reg,
    input  logic [W-1:0] redir_rs_val,
    input  logic [W-1:0] redir_imm,
    input  logic [W-1:0] redir_pc,
    output logic         take,
    output logic [W-1:0] target
);

    logic [W-1:0] base;

    // Offset targets are relative to the instruction after the redirecting
    // one; overflow simply wraps.
    always_comb begin
        take   = redir_jump | (redir_can_branch & redir_branch_take);
        base   = redir_src_reg ? redir_rs_val : redir_imm;
        target = redir_targ_else_offset ? base
                                        : (redir_pc + base + W'(INST_BYTES));
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
// Instruction fetch stage: owns the PC, issues one outstanding request at a
// time to instruction memory (req/gnt, then rvalid/rdata), and presents the
// fetched word to decode with a valid/ready handshake. Late redirects from
// branch resolution override everything; responses made stale by a redirect
// are dropped.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   stall               : blocks new request issue and decode acceptance
//   redir_*             : redirect request and target operands
//   imem_req/imem_addr  : request to instruction memory
//   imem_gnt            : memory accepted the request
//   imem_rvalid/rdata   : instruction response
//   if_valid/if_pc/if_inst/if_ready : handshake to decode
//   fetch_fault         : only with PC_ALIGN_CHECK_EN; misaligned redirect
// Optional feature macro: PC_ALIGN_CHECK_EN.
// ---------------------------------------------------------------------------
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int           W            = WORD_WIDTH,
    parameter logic [W-1:0] RESET_VECTOR = '0,
    parameter int           INST_BYTES   = INST_BYTES_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         redir_jump,
    input  logic         redir_can_branch,
    input  logic         redir_branch_take,
    input  logic         redir_targ_else_offset,
    input  logic         redir_src_reg,
    input  logic [W-1:0] redir_rs_val,
    input  logic [W-1:0] redir_imm,
    input  logic [W-1:0] redir_pc,
    output logic         imem_req,
    output logic [W-1:0] imem_addr,
    input  logic         imem_gnt,
    input  logic         imem_rvalid,
    input  logic [W-1:0] imem_rdata,
    output logic         if_valid,
    output logic [W-1:0] if_pc,
    output logic [W-1:0] if_inst,
    input  logic         if_ready
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic         fetch_fault
`endif
);

    fetch_state_e state_q, state_d;
    logic [W-1:0] pc_q, pc_d;
    logic         drop_q, drop_d;
    logic [W-1:0] if_pc_q, if_pc_d;
    logic [W-1:0] if_inst_q, if_inst_d;
    logic         take;
    logic [W-1:0] target;
    logic         accept;
`ifdef PC_ALIGN_CHECK_EN
    logic         fault_q, fault_d;
`endif

    pc_target_calc #(
        .W          (W),
        .INST_BYTES (INST_BYTES)
    ) u_target (
        .redir_jump             (redir_jump),
        .redir_can_branch       (redir_can_branch),
        .redir_branch_take      (redir_branch_take),
        .redir_targ_else_offset (redir_targ_else_offset),
        .redir_src_reg          (redir_src_reg),
        .redir_rs_val           (redir_rs_val),
        .redir_imm              (redir_imm),
        .redir_pc               (redir_pc),
        .take                   (take),
        .target                 (target)
    );

    assign accept    = (state_q == FETCH_HOLD) & if_ready & ~stall;
    assign imem_req  = (state_q == FETCH_REQ);
    assign imem_addr = pc_q;
    assign if_valid  = (state_q == FETCH_HOLD);
    assign if_pc     = if_pc_q;
    assign if_inst   = if_inst_q;
`ifdef PC_ALIGN_CHECK_EN
    assign fetch_fault = fault_q;
`endif

    // Next-state logic. A redirect is handled first and wins over every
    // other event. drop marks that the single outstanding request belongs to
    // a discarded path, so its response must be swallowed before refetching.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drop_d    = drop_q;
        if_pc_d   = if_pc_q;
        if_inst_d = if_inst_q;
`ifdef PC_ALIGN_CHECK_EN
        fault_d   = fault_q;
`endif
        if (take) begin
            pc_d = target;
            case (state_q)
                FETCH_REQ: begin
                    if (imem_gnt) begin
                        drop_d  = 1'b1;
                        state_d = FETCH_WAIT;
                    end else begin
                        state_d = FETCH_REQ;
                    end
                end
                FETCH_WAIT: begin
                    if (imem_rvalid) begin
                        drop_d  = 1'b0;
                        state_d = FETCH_REQ;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = FETCH_WAIT;
                    end
                end
                default: begin
                    // From FAULT a stale request may still be in flight;
                    // wait it out before issuing the new one.
                    if (drop_q && !imem_rvalid) begin
                        state_d = FETCH_WAIT;
                    end else begin
                        drop_d  = 1'b0;
                        state_d = FETCH_REQ;
                    end
                end
            endcase
`ifdef PC_ALIGN_CHECK_EN
            fault_d = 1'b0;
            if (!is_word_aligned(target)) begin
                fault_d = 1'b1;
                state_d = FETCH_FAULT;
            end
`endif
        end else begin
            case (state_q)
                FETCH_IDLE: begin
                    if (!stall) state_d = FETCH_REQ;
                end
                FETCH_REQ: begin
                    if (imem_gnt) state_d = FETCH_WAIT;
                end
                FETCH_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = stall ? FETCH_IDLE : FETCH_REQ;
                        end else begin
                            if_inst_d = imem_rdata;
                            if_pc_d   = pc_q;
                            state_d   = FETCH_HOLD;
                        end
                    end
                end
                FETCH_HOLD: begin
                    if (accept) begin
                        pc_d    = pc_q + W'(INST_BYTES);
                        state_d = FETCH_REQ;
                    end
                end
                default: begin
                    // FAULT: no fetching; just retire a stale response.
                    if (imem_rvalid) drop_d = 1'b0;
                end
            endcase
        end
    end

    // State register with synchronous reset; reset abandons any request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH_IDLE;
            pc_q      <= RESET_VECTOR;
            drop_q    <= 1'b0;
            if_pc_q   <= ZERO_WORD;
            if_inst_q <= ZERO_WORD;
`ifdef PC_ALIGN_CHECK_EN
            fault_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            drop_q    <= drop_d;
            if_pc_q   <= if_pc_d;
            if_inst_q <= if_inst_d;
`ifdef PC_ALIGN_CHECK_EN
            fault_q   <= fault_d;
`endif
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_ctrl
// Self-checking bench for pc_fetch_ctrl. A small memory model grants every
// request immediately and answers after a programmable latency. Expected
// request addresses and expected decoded PCs are queued up front; a monitor
// pops and compares them as the DUT issues requests and hands off words.
// Optional feature macro exercised: PC_ALIGN_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

    localparam int BOUND = 60;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redir_jump = 1'b0;
    logic        redir_can_branch = 1'b0;
    logic        redir_branch_take = 1'b0;
    logic        redir_targ_else_offset = 1'b0;
    logic        redir_src_reg = 1'b0;
    logic [31:0] redir_rs_val = '0;
    logic [31:0] redir_imm = '0;
    logic [31:0] redir_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
    logic        fetch_fault;
`endif

    int          check_cnt = 0;
    int          err_cnt = 0;
    int          mem_lat = 1;
    logic        mem_pend = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    logic [31:0] exp_req_q[$];
    logic [31:0] exp_out_q[$];

    pc_fetch_ctrl dut (
        .clk                    (clk),
        .rst                    (rst),
        .stall                  (stall),
        .redir_jump             (redir_jump),
        .redir_can_branch       (redir_can_branch),
        .redir_branch_take      (redir_branch_take),
        .redir_targ_else_offset (redir_targ_else_offset),
        .redir_src_reg          (redir_src_reg),
        .redir_rs_val           (redir_rs_val),
        .redir_imm              (redir_imm),
        .redir_pc               (redir_pc),
        .imem_req               (imem_req),
        .imem_addr              (imem_addr),
        .imem_gnt               (imem_gnt),
        .imem_rvalid            (imem_rvalid),
        .imem_rdata             (imem_rdata),
        .if_valid               (if_valid),
        .if_pc                  (if_pc),
        .if_inst                (if_inst),
        .if_ready               (if_ready)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .fetch_fault            (fetch_fault)
`endif
    );

    always #5 clk = ~clk;

    // Memory grants immediately and answers mem_lat cycles after the grant.
    assign imem_gnt = imem_req;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hA5C3_0F1E;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one redirect for exactly one rising edge.
    task automatic applyStimulus(input logic jump, input logic br, input logic tk,
                                 input logic abs_t, input logic src,
                                 input logic [31:0] rs, input logic [31:0] imm,
                                 input logic [31:0] rpc);
        redir_jump = jump; redir_can_branch = br; redir_branch_take = tk;
        redir_targ_else_offset = abs_t; redir_src_reg = src;
        redir_rs_val = rs; redir_imm = imm; redir_pc = rpc;
        @(posedge clk); #1;
        redir_jump = 1'b0; redir_can_branch = 1'b0; redir_branch_take = 1'b0;
    endtask

    task automatic waitReq(input logic [31:0] addr);
        logic found = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge clk);
            if (imem_req && imem_gnt && imem_addr == addr) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("wait_req_seen", {31'd0, found}, 32'd1);
        #1;
    endtask

    task automatic waitValid();
        logic found = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge clk);
            if (if_valid) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("wait_valid_seen", {31'd0, found}, 32'd1);
    endtask

    // Memory response model.
    always @(posedge clk) begin
        imem_rvalid <= 1'b0;
        if (mem_pend) begin
            if (mem_cnt == 0) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= inst_of(mem_addr);
                mem_pend    <= 1'b0;
            end else begin
                mem_cnt <= mem_cnt - 1;
            end
        end
        if (imem_req && imem_gnt) begin
            mem_pend <= 1'b1;
            mem_addr <= imem_addr;
            mem_cnt  <= mem_lat - 1;
        end
    end

    // Scoreboard monitor: compare each grant and each decode hand-off
    // against the next queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_req && imem_gnt) begin
                if (exp_req_q.size() == 0) checkOutput("req_unexpected", imem_addr, 32'hFFFF_FFFF);
                else checkOutput("req_addr", imem_addr, exp_req_q.pop_front());
            end
            if (if_valid && if_ready && !stall) begin
                if (exp_out_q.size() == 0) begin
                    checkOutput("out_unexpected", if_pc, 32'hFFFF_FFFF);
                end else begin
                    logic [31:0] e;
                    e = exp_out_q.pop_front();
                    checkOutput("out_pc", if_pc, e);
                    checkOutput("out_inst", if_inst, inst_of(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] held_inst;
        exp_req_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h400, 32'h404, 32'h408,
                      32'h2C, 32'h30, 32'h0, 32'h4};
`ifdef PC_ALIGN_CHECK_EN
        exp_req_q.push_back(32'h200);
`else
        exp_req_q.push_back(32'h102);
`endif
        exp_out_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h400, 32'h404, 32'h2C, 32'h0};

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
        checkOutput("rst_addr", imem_addr, 32'h0);
        checkOutput("rst_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("rst_if_pc", if_pc, 32'h0);
        checkOutput("rst_if_inst", if_inst, 32'h0);
`ifdef PC_ALIGN_CHECK_EN
        checkOutput("rst_fault", {31'd0, fetch_fault}, 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;

        // Sequential fetch, then absolute jump while 0x10 is being granted.
        waitReq(32'h10);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h400, 32'h0);
        mem_lat = 3;

        // Taken branch, offset mode, issued while waiting on 0x408.
        waitReq(32'h408);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h8, 32'h20);
        if_ready = 1'b0;

        // Backpressure then stall on the 0x2C word.
        waitValid();
        checkOutput("hold_pc", if_pc, 32'h2C);
        checkOutput("hold_inst", if_inst, inst_of(32'h2C));
        held_inst = if_inst;
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp_valid", {31'd0, if_valid}, 32'd1);
            checkOutput("bp_inst", if_inst, inst_of(32'h2C));
            checkOutput("bp_no_req", {31'd0, imem_req}, 32'd0);
        end
        @(posedge clk); #1;
        stall = 1'b1;
        if_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("stall_valid", {31'd0, if_valid}, 32'd1);
            checkOutput("stall_no_req", {31'd0, imem_req}, 32'd0);
        end
        @(posedge clk); #1;
        stall = 1'b0;
        mem_lat = 1;

        // Offset redirect that wraps: 0xFFFF_FFF8 + 4 + 4 = 0.
        waitReq(32'h30);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4, 32'h0, 32'hFFFF_FFF8);
        waitReq(32'h4);
        @(posedge clk); #1;
        if_ready = 1'b0;
        waitValid();
        checkOutput("hold4_pc", if_pc, 32'h4);
        #1;

        // Misaligned jump from HOLD.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h102, 32'h0);
`ifdef PC_ALIGN_CHECK_EN
        repeat (3) begin
            @(negedge clk);
            checkOutput("fault_flag", {31'd0, fetch_fault}, 32'd1);
            checkOutput("fault_no_req", {31'd0, imem_req}, 32'd0);
            checkOutput("fault_no_valid", {31'd0, if_valid}, 32'd0);
            checkOutput("fault_pc", imem_addr, 32'h102);
        end
        #1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 32'h0);
        @(negedge clk);
        checkOutput("fault_clear", {31'd0, fetch_fault}, 32'd0);
        checkOutput("refetch_req", {31'd0, imem_req}, 32'd1);
        checkOutput("refetch_addr", imem_addr, 32'h200);
        waitValid();
        checkOutput("refetch_pc", if_pc, 32'h200);
        checkOutput("refetch_inst", if_inst, inst_of(32'h200));
`else
        waitReq(32'h102);
        waitValid();
        checkOutput("misalign_pc", if_pc, 32'h102);
        checkOutput("misalign_inst", if_inst, inst_of(32'h102));
`endif

        repeat (5) @(negedge clk);
        checkOutput("req_q_left", exp_req_q.size(), 32'd0);
        checkOutput("out_q_left", exp_out_q.size(), 32'd0);
        checkOutput("first_hold_inst", held_inst, inst_of(32'h2C));

        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end

endmodule
